// File: rtl/instr_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package instr_prefetch_pkg;

  // Fetch control state.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int unsigned DEPTH_DEF = 4;   // default queue depth
  localparam int unsigned PC_INC    = 4;   // bytes per instruction word
  localparam int unsigned INSTR_W   = 32;  // instruction word width

endpackage

// File: rtl/prefetch_fifo.sv
// Circular queue holding fetched {instr, pc} entries; flush empties it in one edge.
module prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_c, pop_ok_c;

  // Flush dominates; pop is ignored on an empty queue.
  always_comb begin
    push_ok_c = push & ~flush;
    pop_ok_c  = pop & ~flush & (count_q != '0);
    mem_d     = mem_q;
    if (push_ok_c) mem_d[wr_ptr_q] = wdata;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok_c);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok_c);
      count_d  = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/instr_prefetch.sv
// Single-outstanding instruction prefetcher feeding a small FIFO.
// Optional macro INSTR_PREFETCH_BYPASS_EN: ack data is presented to the
// consumer in the ack cycle when the queue is empty.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned PC_W  = 64
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [PC_W-1:0]    startPC,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirectPC,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = INSTR_W + PC_W;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;

  logic              ack_c, bypass_c, push_c, pop_c, flush_c, fifo_empty_c;
  logic [CNT_W-1:0]  fifo_count_c;
  logic [ENT_W-1:0]  fifo_head_c;

  // An ack only counts while a request is actually outstanding.
  assign ack_c = mem_req_q & mem_ack & ~Reset;

`ifdef INSTR_PREFETCH_BYPASS_EN
  assign bypass_c = ack_c & (state_q == RUN) & ~redirect & fifo_empty_c;
`else
  assign bypass_c = 1'b0;
`endif

  assign pop_c = instr_ready & ~fifo_empty_c;

  // Next-state, request issue and queue control.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push_c     = 1'b0;
    flush_c    = 1'b0;
    if (redirect) begin
      flush_c    = 1'b1;
      fetch_pc_d = redirectPC & ~PC_W'(3);
      if (ack_c) begin
        mem_req_d = 1'b0;
        state_d   = RUN;
      end else if (mem_req_q) begin
        state_d = DRAIN;
      end
    end else begin
      case (state_q)
        DRAIN: begin
          if (ack_c) begin
            mem_req_d = 1'b0;
            state_d   = RUN;
          end
        end
        default: begin
          if (ack_c) begin
            mem_req_d  = 1'b0;
            fetch_pc_d = fetch_pc_q + PC_W'(PC_INC);
            push_c     = ~(bypass_c & instr_ready);
          end else if (!mem_req_q && (fifo_count_c < CNT_W'(DEPTH))) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
          end
        end
      endcase
    end
  end

  // Control and request registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= RUN;
      fetch_pc_q <= startPC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= startPC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (Reset),
    .push  (push_c),
    .wdata ({mem_rdata, mem_addr_q}),
    .pop   (pop_c),
    .flush (flush_c),
    .rdata (fifo_head_c),
    .count (fifo_count_c),
    .empty (fifo_empty_c)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = ~fifo_empty_c | bypass_c;
  assign {instr, instr_pc} = fifo_empty_c ? {mem_rdata, mem_addr_q} : fifo_head_c;

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_instr_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 64;

  logic            CLK;
  logic            Reset;
  logic [63:0]     startPC;
  logic            redirect;
  logic [63:0]     redirectPC;
  logic            mem_req;
  logic [63:0]     mem_addr;
  logic            mem_ack;
  logic [31:0]     mem_rdata;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [63:0]     instr_pc;
  logic            instr_ready;

  instr_prefetch #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .startPC     (startPC),
    .redirect    (redirect),
    .redirectPC  (redirectPC),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed { logic [31:0] w; logic [63:0] pc; } ent_t;
  typedef struct { logic req; logic [63:0] addr; logic valid; logic [63:0] pc; } vec_t;

  int   n_checks, n_err, cyc;
  bit   model_ok;
  int   lat_cur, lat_cnt, fixed_lat;
  bit   rand_lat;
  bit   ok;

  // Reference model: transaction-level view of the prefetcher.
  ent_t        mq[$];
  bit          m_out, m_drain;
  logic [63:0] m_addr, m_fetch;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s cycle %0d: timed out waiting for DUT", name, cyc);
  endtask

  // Memory: acks in the lat_cur-th cycle of a request, returns word_of(addr).
  task automatic mem_drive();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_req === 1'b1 && lat_cnt + 1 >= lat_cur) begin
      mem_ack   = 1'b1;
      mem_rdata = word_of(mem_addr);
    end
  endtask

  task automatic mem_update();
    if (Reset || mem_req !== 1'b1 || mem_ack) begin
      lat_cnt = 0;
      lat_cur = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
    end else begin
      lat_cnt++;
    end
  endtask

  task automatic model_compare();
    logic exp_valid;
    ent_t head;
    exp_valid = (mq.size() > 0);
    head      = exp_valid ? mq[0] : '0;
`ifdef INSTR_PREFETCH_BYPASS_EN
    if (!exp_valid && !m_drain && m_out && mem_ack && !redirect && !Reset) begin
      exp_valid = 1'b1;
      head      = {mem_rdata, m_addr};
    end
`endif
    chk("mem_req", 64'(mem_req), 64'(m_out));
    chk("mem_addr", mem_addr, m_addr);
    chk("instr_valid", 64'(instr_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("instr", 64'(instr), 64'(head.w));
      chk("instr_pc", instr_pc, head.pc);
    end
  endtask

  task automatic model_update();
    bit ack, byp;
    int n;
    if (Reset) begin
      mq.delete();
      m_out   = 1'b0;
      m_drain = 1'b0;
      m_addr  = startPC;
      m_fetch = startPC;
      return;
    end
    ack = m_out && mem_ack;
    n   = mq.size();
    byp = 1'b0;
`ifdef INSTR_PREFETCH_BYPASS_EN
    byp = (n == 0) && !m_drain && ack && !redirect && instr_ready;
`endif
    if (instr_ready && n > 0) void'(mq.pop_front());
    if (redirect) begin
      mq.delete();
      m_fetch = {redirectPC[63:2], 2'b00};
      if (ack) begin
        m_out   = 1'b0;
        m_drain = 1'b0;
      end else if (m_out) begin
        m_drain = 1'b1;
      end
    end else if (m_drain) begin
      if (ack) begin
        m_out   = 1'b0;
        m_drain = 1'b0;
      end
    end else if (ack) begin
      if (!byp) mq.push_back({mem_rdata, m_addr});
      m_fetch = m_fetch + 64'd4;
      m_out   = 1'b0;
    end else if (!m_out && n < int'(DEPTH)) begin
      m_out  = 1'b1;
      m_addr = m_fetch;
    end
  endtask

  // Compare at the falling edge, advance model and memory, land at posedge+1.
  task automatic finish_cycle();
    @(negedge CLK);
    if (model_ok) model_compare();
    if (Reset) model_ok = 1'b1;
    model_update();
    mem_update();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Returns mid-cycle (after mem_drive) once the condition holds; caller finishes the cycle.
  // what: 0 mem_req high, 1 instr_valid high, 2 memory acking this cycle.
  task automatic wait_for(input int what, input int limit, input string name, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < limit; i++) begin
      mem_drive();
      #1;
      if ((what == 0 && mem_req === 1'b1) || (what == 1 && instr_valid === 1'b1) ||
          (what == 2 && mem_ack === 1'b1)) begin
        hit = 1'b1;
        return;
      end
      finish_cycle();
    end
    mem_drive();
    #1;
    timeout(name);
  endtask

  task automatic do_reset(input logic [63:0] pc, input int n);
    Reset    = 1'b1;
    startPC  = pc;
    redirect = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_drive();
      finish_cycle();
    end
    Reset = 1'b0;
  endtask

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_err = 0; cyc = 0; model_ok = 1'b0;
    Reset = 1'b1; startPC = 64'h1000; redirect = 1'b0; redirectPC = '0;
    mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    rand_lat = 1'b0; fixed_lat = 2; lat_cur = 2; lat_cnt = 0;

    // Basic stream: startPC 0x1000, ack latency 2, consumer always ready.
`ifdef INSTR_PREFETCH_BYPASS_EN
    tbl = '{'{0, 64'h1000, 0, 64'h0},    '{1, 64'h1000, 0, 64'h0},
            '{1, 64'h1000, 1, 64'h1000}, '{0, 64'h1000, 0, 64'h0},
            '{1, 64'h1004, 0, 64'h0},    '{1, 64'h1004, 1, 64'h1004},
            '{0, 64'h1004, 0, 64'h0},    '{1, 64'h1008, 0, 64'h0},
            '{1, 64'h1008, 1, 64'h1008}, '{0, 64'h1008, 0, 64'h0}};
`else
    tbl = '{'{0, 64'h1000, 0, 64'h0},    '{1, 64'h1000, 0, 64'h0},
            '{1, 64'h1000, 0, 64'h0},    '{0, 64'h1000, 1, 64'h1000},
            '{1, 64'h1004, 0, 64'h0},    '{1, 64'h1004, 0, 64'h0},
            '{0, 64'h1004, 1, 64'h1004}, '{1, 64'h1008, 0, 64'h0},
            '{1, 64'h1008, 0, 64'h0},    '{0, 64'h1008, 1, 64'h1008}};
`endif
    instr_ready = 1'b1;
    do_reset(64'h1000, 2);
    for (int i = 0; i < 10; i++) begin
      mem_drive();
      #1;
      chk($sformatf("tbl%0d_req", i), 64'(mem_req), 64'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 64'(instr_valid), 64'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), 64'(instr), 64'(word_of(tbl[i].pc)));
      end
      finish_cycle();
    end

    // Consumer stalled: queue fills to DEPTH, requests stop, then drains in order.
    fixed_lat = 1; instr_ready = 1'b0;
    do_reset(64'h1000, 2);
    for (int i = 0; i < 30; i++) begin mem_drive(); finish_cycle(); end
    for (int i = 0; i < 3; i++) begin
      mem_drive(); #1;
      chk("full_no_req", 64'(mem_req), 64'd0);
      chk("full_head_pc", instr_pc, 64'h1000);
      finish_cycle();
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_drive(); #1;
      chk("pop_valid", 64'(instr_valid), 64'd1);
      chk("pop_pc", instr_pc, 64'h1000 + 64'(4 * i));
      finish_cycle();
    end
    wait_for(1, 20, "resume_valid", ok);
    if (ok) chk("resume_pc", instr_pc, 64'h1010);
    finish_cycle();

    // Redirect to an unaligned target while a request is outstanding.
    fixed_lat = 4;
    do_reset(64'h1000, 2);
    wait_for(0, 10, "drain_req", ok);
    redirect = 1'b1; redirectPC = 64'h2003;
    finish_cycle();
    redirect = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      mem_drive(); #1;
      chk("drain_req_held", 64'(mem_req), 64'd1);
      chk("drain_no_valid", 64'(instr_valid), 64'd0);
      ok = mem_ack;
      finish_cycle();
    end
    if (!ok) timeout("drain_ack");
    wait_for(0, 10, "refetch_req", ok);
    if (ok) chk("refetch_addr", mem_addr, 64'h2000);
    finish_cycle();
    wait_for(1, 20, "refetch_valid", ok);
    if (ok) chk("refetch_pc", instr_pc, 64'h2000);
    finish_cycle();

    // Redirect in the same cycle as mem_ack.
    fixed_lat = 2;
    do_reset(64'h1000, 2);
    wait_for(2, 10, "coinc_ack", ok);
    redirect = 1'b1; redirectPC = 64'h3000;
    finish_cycle();
    redirect = 1'b0;
    mem_drive(); #1;
    chk("coinc_no_valid", 64'(instr_valid), 64'd0);
    chk("coinc_no_req", 64'(mem_req), 64'd0);
    finish_cycle();
    wait_for(0, 5, "coinc_refetch", ok);
    if (ok) chk("coinc_addr", mem_addr, 64'h3000);
    finish_cycle();
    wait_for(1, 20, "coinc_valid", ok);
    if (ok) chk("coinc_pc", instr_pc, 64'h3000);
    finish_cycle();

    // Redirect in the same cycle as a pop.
    fixed_lat = 1; instr_ready = 1'b0;
    do_reset(64'h1000, 2);
    wait_for(1, 20, "pop_redir_valid", ok);
    instr_ready = 1'b1; redirect = 1'b1; redirectPC = 64'h4000;
    finish_cycle();
    redirect = 1'b0;
    mem_drive(); #1;
    chk("pop_redir_empty", 64'(instr_valid), 64'd0);
    finish_cycle();
    wait_for(1, 20, "pop_redir_refetch", ok);
    if (ok) begin
      chk("pop_redir_pc", instr_pc, 64'h4000);
      chk("pop_redir_instr", 64'(instr), 64'(word_of(64'h4000)));
    end
    finish_cycle();

    // Fetch address wraps past the top of the address space.
    do_reset(64'hFFFF_FFFF_FFFF_FFFC, 2);
    wait_for(0, 5, "wrap_req0", ok);
    if (ok) chk("wrap_addr0", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    finish_cycle();
    mem_drive(); #1;
    chk("wrap_gap", 64'(mem_req), 64'd0);
    finish_cycle();
    wait_for(0, 5, "wrap_req1", ok);
    if (ok) chk("wrap_addr1", mem_addr, 64'h0);
    finish_cycle();

    // Reset mid-request with a stray ack during reset.
    fixed_lat = 3;
    do_reset(64'h5000, 2);
    wait_for(0, 5, "rst_req", ok);
    finish_cycle();
    Reset = 1'b1;
    mem_drive(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    finish_cycle();
    mem_drive();
    finish_cycle();
    Reset = 1'b0;
    mem_drive(); #1;
    chk("rst_no_req", 64'(mem_req), 64'd0);
    chk("rst_no_valid", 64'(instr_valid), 64'd0);
    chk("rst_addr", mem_addr, 64'h5000);
    finish_cycle();
    wait_for(1, 20, "rst_valid", ok);
    if (ok) chk("rst_first_pc", instr_pc, 64'h5000);
    finish_cycle();

    // Randomized traffic checked every cycle by the model.
    rand_lat = 1'b1;
    do_reset({$urandom, $urandom} & ~64'h3, 2);
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 299) == 0);
      if (Reset) startPC = {$urandom, $urandom} & ~64'h3;
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 24) == 0);
      redirectPC  = {$urandom, $urandom};
      mem_drive();
      finish_cycle();
    end
    Reset = 1'b0; redirect = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
